cordic_arbiter: RTL and testbench
=================================

# cordic_arbiter

Shares the single CORDIC core between two requesters (channel 0, channel 1), e.g. the AHB-Lite CORDIC slave and a DMA engine. Operands are issued to the core one per cycle. An in-order tag FIFO records which channel owns each in-flight operation. Each result is routed back to its owner when the core signals completion.

## Interface
- `DATA_W`, 32, operand/result width
- `MAX_OUT`, 4, max in-flight operations; power of two, 2..16
- `CNT_W`, $clog2(MAX_OUT)+1, outstanding-counter width
- `HCLK`  in  1  clock; all logic on rising edge
- `HRESETn`  in  1  reset, asynchronous assert, active low
- `req0_valid` / `req1_valid`  in  1  channel has an operand
- `req0_data` / `req1_data`  in  DATA_W  operand
- `req0_ready` / `req1_ready`  out  1  combinational grant; transfer when valid && ready
- `rsp0_valid` / `rsp1_valid`  out  1  one-cycle result strobe; no backpressure
- `rsp0_data` / `rsp1_data`  out  DATA_W  result, held until next strobe on that channel
- `core_in`  out  DATA_W  operand to CORDIC
- `core_valid_in`  out  1  one-cycle issue strobe
- `core_valid_out`  in  1  core result strobe
- `core_out`  in  DATA_W  core result
- `outstanding`  out  CNT_W  in-flight count
- `err_orphan`  out  1  sticky: result arrived with no tag pending

## Operation
- Issue is allowed when `outstanding < MAX_OUT`.
- At `outstanding == MAX_OUT`, issue is blocked, even if a retire occurs in the same cycle.
- Grant, default round-robin:
  - Only one valid: that channel is granted.
  - Both valid: the channel not granted last is granted.
  - The last-grant pointer updates only on an actual transfer.
  - Reset value is "last = 1", so channel 0 wins the first tie.
- At most one ready is high per cycle. Ready is never high while issue is blocked.
- On transfer:
  - `core_in` ← operand and `core_valid_in` ← 1 for exactly one cycle.
  - The channel ID is pushed into the tag FIFO (depth `MAX_OUT`, 1 bit wide).
- On `core_valid_out`, tag FIFO not empty:
  - The head tag is popped.
  - The owning channel's `rsp_data` ← `core_out` and `rsp_valid` ← 1 for one cycle. The other channel's `rsp_valid` stays 0.
- On `core_valid_out`, tag FIFO empty:
  - No pop and no response.
  - `err_orphan` ← 1; it is cleared only by reset.
- `outstanding` changes per cycle:
  - +1 on issue only.
  - −1 on valid retire only.
  - Unchanged when issue and retire happen in the same cycle.
- The FIFO read and write pointers wrap modulo `MAX_OUT`. Full/empty are derived from `outstanding`.
- Reset values of all outputs:
  - `core_in`, `rsp*_data`: 0.
  - `core_valid_in`, `rsp*_valid`, `err_orphan`: 0.
  - `outstanding`: 0.
  - `req*_ready`: 0 while `HRESETn` is low.
- Reset mid-operation discards all tags. Results from the core after reset release count as orphans.

## Timing
- Issue latency: a transfer at edge N gives `core_valid_in` high in cycle N+1 (edge N to edge N+1).
- Response latency: `core_valid_out` sampled at edge M gives `rsp*_valid` high in cycle M+1.
- Throughput: one issue and one retire per cycle, sustained.
- `req*_ready` depends combinationally on `req*_valid`, the pointer and `outstanding`. It has no path from `core_valid_out`.

## Configuration
- Macro: `CORDIC_ARB_FIXED_PRIO_EN`.
- Defined: fixed priority, channel 0 always wins a tie. The last-grant pointer is not built.
- Undefined: round-robin as described above.

## Test plan
- Reset, then `req0_valid` with 0x00001234 → `req0_ready` high the same cycle; next cycle `core_valid_in`=1 with `core_in`=0x00001234; `outstanding`=1.
- Both channels valid for 4 cycles, core silent, `MAX_OUT`=4 → grants 0,1,0,1; `outstanding`=4; both readies 0 on the 5th cycle.
  - With `CORDIC_ARB_FIXED_PRIO_EN`, the grants are 0,0,0,0.
- Issue ch1 (0xA), then ch0 (0xB); core returns 0x111 then 0x222 → `rsp1_valid` with 0x111, then `rsp0_valid` with 0x222; `outstanding` returns to 0.
- At `outstanding`=3, issue and retire in the same cycle → `outstanding` stays 3.
- At `outstanding`=4, a retire with `req0_valid` high → no grant that cycle; grant the next cycle.
- `core_valid_out` with 0 outstanding → `err_orphan`=1 and stays 1; no `rsp*_valid`; `outstanding` stays 0.
- Assert `HRESETn` low asynchronously mid-burst → all outputs 0 immediately; `err_orphan` cleared.

Source files
------------

// File: rtl/cordic_arbiter.sv
// rtl/cordic_arbiter.sv - two-channel issue arbiter and in-order result router for a shared CORDIC core
// Define CORDIC_ARB_FIXED_PRIO_EN for fixed channel-0 priority; default is round-robin.
module cordic_arbiter #(
    parameter int DATA_W  = 32,
    parameter int MAX_OUT = 4,
    parameter int CNT_W   = $clog2(MAX_OUT) + 1
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_data,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_data,
    output logic [DATA_W-1:0] core_in,
    output logic              core_valid_in,
    input  logic              core_valid_out,
    input  logic [DATA_W-1:0] core_out,
    output logic [CNT_W-1:0]  outstanding,
    output logic              err_orphan
);
    localparam int PTR_W = $clog2(MAX_OUT);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUT);

    logic               can_issue;
    logic               grant0;
    logic               grant1;
    logic               issue;
    logic               issue_ch;
    logic               retire;
    logic               head_tag;
    logic [MAX_OUT-1:0] tag_mem;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;

    // Full check uses the registered count only, so a same-cycle retire never frees a slot.
    assign can_issue = HRESETn && (outstanding < FULL_CNT);

`ifdef CORDIC_ARB_FIXED_PRIO_EN
    assign grant0 = req0_valid;
    assign grant1 = req1_valid && !req0_valid;
`else
    logic last_grant;

    assign grant0 = req0_valid && (!req1_valid || last_grant);
    assign grant1 = req1_valid && (!req0_valid || !last_grant);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            last_grant <= 1'b1;
        end else if (issue) begin
            last_grant <= issue_ch;
        end
    end
`endif

    assign req0_ready = can_issue && grant0;
    assign req1_ready = can_issue && grant1;
    assign issue      = req0_ready || req1_ready;
    assign issue_ch   = req1_ready;
    assign retire     = core_valid_out && (outstanding != '0);
    assign head_tag   = tag_mem[rd_ptr];

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            core_in       <= '0;
            core_valid_in <= 1'b0;
            rsp0_valid    <= 1'b0;
            rsp0_data     <= '0;
            rsp1_valid    <= 1'b0;
            rsp1_data     <= '0;
            outstanding   <= '0;
            err_orphan    <= 1'b0;
            tag_mem       <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
        end else begin
            core_valid_in <= issue;
            if (issue) begin
                core_in         <= issue_ch ? req1_data : req0_data;
                tag_mem[wr_ptr] <= issue_ch;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end

            rsp0_valid <= retire && !head_tag;
            rsp1_valid <= retire && head_tag;
            if (retire) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                if (head_tag) begin
                    rsp1_data <= core_out;
                end else begin
                    rsp0_data <= core_out;
                end
            end

            if (core_valid_out && (outstanding == '0)) begin
                err_orphan <= 1'b1;
            end

            if (issue && !retire) begin
                outstanding <= outstanding + CNT_W'(1);
            end else if (retire && !issue) begin
                outstanding <= outstanding - CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_cordic_arbiter.sv
// tb/tb_cordic_arbiter.sv - self-checking bench for cordic_arbiter
module tb_cordic_arbiter;
    localparam int DW = 32;
    localparam int MO = 4;
    localparam int CW = $clog2(MO) + 1;
`ifdef CORDIC_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic          HCLK = 1'b0;
    logic          HRESETn = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic [DW-1:0] req0_data = '0, req1_data = '0;
    logic          req0_ready, req1_ready;
    logic          rsp0_valid, rsp1_valid;
    logic [DW-1:0] rsp0_data, rsp1_data;
    logic [DW-1:0] core_in;
    logic          core_valid_in;
    logic          core_valid_out = 1'b0;
    logic [DW-1:0] core_out = '0;
    logic [CW-1:0] outstanding;
    logic          err_orphan;

    cordic_arbiter #(.DATA_W(DW), .MAX_OUT(MO), .CNT_W(CW)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
        .core_in(core_in), .core_valid_in(core_valid_in),
        .core_valid_out(core_valid_out), .core_out(core_out),
        .outstanding(outstanding), .err_orphan(err_orphan)
    );

    always #5 HCLK = ~HCLK;

    int errors = 0;
    int checks = 0;

    // Reference model: owner queue plus last-winner and held output values.
    bit            m_tags[$];
    int            m_last;
    logic [DW-1:0] m_core_in, m_rsp0_data, m_rsp1_data;
    bit            m_cvi, m_rv0, m_rv1, m_err;

    typedef struct {
        bit v0; bit v1; bit cov;
        int g_rr; int g_fx; int cnt;
    } vec_t;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int model_grant();
        if (m_tags.size() == MO) return 2;
        if (req0_valid && req1_valid) return FIXED ? 0 : ((m_last == 1) ? 0 : 1);
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return 2;
    endfunction

    task automatic model_reset();
        m_tags.delete();
        m_last = 1;
        m_core_in = '0; m_rsp0_data = '0; m_rsp1_data = '0;
        m_cvi = 0; m_rv0 = 0; m_rv1 = 0; m_err = 0;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_ready0"}, req0_ready, 0);
        chk({tag, "_ready1"}, req1_ready, 0);
        chk({tag, "_cvi"}, core_valid_in, 0);
        chk({tag, "_core_in"}, core_in, 0);
        chk({tag, "_rv0"}, rsp0_valid, 0);
        chk({tag, "_rv1"}, rsp1_valid, 0);
        chk({tag, "_rd0"}, rsp0_data, 0);
        chk({tag, "_rd1"}, rsp1_data, 0);
        chk({tag, "_outst"}, outstanding, 0);
        chk({tag, "_err"}, err_orphan, 0);
    endtask

    // One clock: readies checked mid-low phase, registered outputs 1ns after the edge.
    task automatic cycle(input string name, input int exp_g, input int exp_cnt);
        int  g;
        bit  tag;
        @(negedge HCLK);
        g = model_grant();
        chk({name, "_ready0"}, req0_ready, (g == 0));
        chk({name, "_ready1"}, req1_ready, (g == 1));
        if (exp_g >= 0) begin
            chk({name, "_tbl_ready0"}, req0_ready, (exp_g == 0));
            chk({name, "_tbl_ready1"}, req1_ready, (exp_g == 1));
        end
        @(posedge HCLK);
        m_rv0 = 0; m_rv1 = 0;
        if (core_valid_out) begin
            if (m_tags.size() > 0) begin
                tag = m_tags.pop_front();
                if (tag) begin m_rv1 = 1; m_rsp1_data = core_out; end
                else     begin m_rv0 = 1; m_rsp0_data = core_out; end
            end else begin
                m_err = 1;
            end
        end
        m_cvi = (g != 2);
        if (g != 2) begin
            m_core_in = (g == 1) ? req1_data : req0_data;
            m_tags.push_back(g[0]);
            m_last = g;
        end
        #1;
        chk({name, "_cvi"}, core_valid_in, m_cvi);
        chk({name, "_core_in"}, core_in, m_core_in);
        chk({name, "_rv0"}, rsp0_valid, m_rv0);
        chk({name, "_rv1"}, rsp1_valid, m_rv1);
        chk({name, "_rd0"}, rsp0_data, m_rsp0_data);
        chk({name, "_rd1"}, rsp1_data, m_rsp1_data);
        chk({name, "_outst"}, outstanding, m_tags.size());
        chk({name, "_err"}, err_orphan, m_err);
        if (exp_cnt >= 0) chk({name, "_tbl_outst"}, outstanding, exp_cnt);
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req1_valid = 0; core_valid_out = 0;
    endtask

    task automatic do_reset(input string tag);
        HRESETn = 0;
        model_reset();
        #1;
        chk_zero_outputs(tag);
        @(posedge HCLK);
        #1;
        HRESETn = 1;
    endtask

    vec_t tbl[13];

    initial begin
        tbl[0]  = '{1, 1, 0, 0, 0, 1};
        tbl[1]  = '{1, 1, 0, 1, 0, 2};
        tbl[2]  = '{1, 1, 0, 0, 0, 3};
        tbl[3]  = '{1, 1, 0, 1, 0, 4};
        tbl[4]  = '{1, 1, 0, 2, 2, 4};
        tbl[5]  = '{1, 1, 1, 2, 2, 3};
        tbl[6]  = '{1, 1, 0, 0, 0, 4};
        tbl[7]  = '{1, 0, 1, 2, 2, 3};
        tbl[8]  = '{1, 0, 1, 0, 0, 3};
        tbl[9]  = '{0, 0, 1, 2, 2, 2};
        tbl[10] = '{0, 0, 1, 2, 2, 1};
        tbl[11] = '{0, 0, 1, 2, 2, 0};
        tbl[12] = '{0, 0, 1, 2, 2, 0};

        // Reset with a request pending: readies must stay low.
        req0_valid = 1; req1_valid = 1;
        model_reset();
        @(posedge HCLK);
        #1;
        chk_zero_outputs("reset");
        HRESETn = 1;
        idle_inputs();

        // Single request on channel 0.
        req0_valid = 1; req0_data = 32'h0000_1234;
        cycle("single", 0, 1);
        chk("single_core_in", core_in, 32'h0000_1234);
        idle_inputs();
        do_reset("rst_a");

        // Grant order, full blocking, retire while full, same-cycle issue+retire, orphan.
        for (int i = 0; i < 13; i++) begin
            req0_valid = tbl[i].v0; req1_valid = tbl[i].v1;
            req0_data = 32'h1000 + i; req1_data = 32'h2000 + i;
            core_valid_out = tbl[i].cov; core_out = 32'hC000 + i;
            cycle($sformatf("tbl%0d", i), FIXED ? tbl[i].g_fx : tbl[i].g_rr, tbl[i].cnt);
        end
        idle_inputs();
        cycle("sticky", 2, 0);
        chk("sticky_err", err_orphan, 1);
        do_reset("rst_b");

        // Routing: ch1 then ch0, results return in order to their owners.
        req1_valid = 1; req1_data = 32'hA;
        cycle("rt_iss1", 1, 1);
        req1_valid = 0; req0_valid = 1; req0_data = 32'hB;
        cycle("rt_iss0", 0, 2);
        idle_inputs(); core_valid_out = 1; core_out = 32'h111;
        cycle("rt_ret1", 2, 1);
        chk("rt_rsp1_valid", rsp1_valid, 1);
        chk("rt_rsp1_data", rsp1_data, 32'h111);
        core_out = 32'h222;
        cycle("rt_ret0", 2, 0);
        chk("rt_rsp0_valid", rsp0_valid, 1);
        chk("rt_rsp0_data", rsp0_data, 32'h222);
        idle_inputs();
        cycle("rt_idle", 2, 0);

        // Randomised traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 3) != 0);
            req0_data = $urandom; req1_data = $urandom;
            core_valid_out = ($urandom_range(0, 1) == 1); core_out = $urandom;
            cycle("rnd", -1, -1);
        end

        // Asynchronous reset mid-burst, then a core result after release is an orphan.
        req0_valid = 1; req1_valid = 1; core_valid_out = 0;
        cycle("burst0", -1, -1);
        cycle("burst1", -1, -1);
        #2;
        HRESETn = 0;
        model_reset();
        #1;
        chk_zero_outputs("async");
        @(posedge HCLK);
        #1;
        HRESETn = 1;
        idle_inputs(); core_valid_out = 1; core_out = 32'hDEAD;
        cycle("post_rst", 2, 0);
        chk("post_rst_err", err_orphan, 1);
        idle_inputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
